// File: rtl/conv_pe_ctrl_pkg.sv
// Shared types and constants for the 3x3 conv PE sequencer.
package conv_ctrl_pkg;

  localparam int unsigned NUM_TAPS = 9;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoadW  = 3'd1,
    StStream = 3'd2,
    StDrain  = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Minimum 1 bit so degenerate sizes still give a legal vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_pe_ctrl_if.sv
// Control, stream and PE-side signals of the conv PE sequencer.
interface conv_pe_ctrl_if #(
  parameter int unsigned WIDTH = 9
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 wt_valid;
  logic                 wt_ready;
  logic [WIDTH-1:0]     wt_data;
  logic                 px_valid;
  logic                 px_ready;
  logic [WIDTH-1:0]     px_data;
  logic [WIDTH-1:0]     pe_weight;
  logic [3:0]           pe_weight_idx;
  logic                 pe_weight_we;
  logic [WIDTH-1:0]     pe_data;
  logic                 pe_data_en;
  logic                 pe_rst_n;
  logic [2*WIDTH-1:0]   pe_result;
  logic                 res_valid;
  logic [2*WIDTH-1:0]   res_data;

  modport master (
    input  start, wt_valid, wt_data, px_valid, px_data, pe_result,
    output busy, done, wt_ready, px_ready, pe_weight, pe_weight_idx, pe_weight_we,
           pe_data, pe_data_en, pe_rst_n, res_valid, res_data
  );

  modport slave (
    output start, wt_valid, wt_data, px_valid, px_data, pe_result,
    input  busy, done, wt_ready, px_ready, pe_weight, pe_weight_idx, pe_weight_we,
           pe_data, pe_data_en, pe_rst_n, res_valid, res_data
  );
endinterface

// File: rtl/conv_pe_ctrl_win_tracker.sv
// Pixel row/col tracking and full-window tag pipeline aligned to the PE result.
module conv_win_tracker
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W  = 10,
  parameter int unsigned IMG_H  = 10,
  parameter int unsigned CU_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic clear,
  output logic last_px,
  output logic tag_out
);
  localparam int unsigned ColW = clog2(IMG_W);
  localparam int unsigned RowW = clog2(IMG_H);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [CU_LAT:0] tag_q, tag_d;
  logic            win_tag;

  assign win_tag = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
  assign last_px = accept && (row_q == RowW'(IMG_H - 1)) && (col_q == ColW'(IMG_W - 1));
  assign tag_out = tag_q[CU_LAT];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == ColW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Tags advance every cycle so they stay locked to the fixed PE latency.
  always_comb begin
    tag_d    = '0;
    tag_d[0] = win_tag;
    for (int i = 1; i <= int'(CU_LAT); i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      tag_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/conv_pe_ctrl.sv
// Sequencer for a 3x3 shift-register conv PE: weight load, image stream, result tagging.
module conv_pe_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned IMG_W  = 10,
  parameter int unsigned IMG_H  = 10,
  parameter int unsigned CU_LAT = 2
) (
  input logic          clk,
  input logic          rst_n,
  conv_pe_ctrl_if.master bus
);
  localparam int unsigned DrainW = clog2(CU_LAT + 2);

  state_e              state_q, state_d;
  logic [3:0]          widx_q, widx_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                clear;
  logic                wt_hs, px_hs;
  logic                last_px, tag_out;

  logic                we_q;
  logic [WIDTH-1:0]    weight_q;
  logic [3:0]          idx_q;
  logic                en_q;
  logic [WIDTH-1:0]    data_q;
  logic                res_valid_q;
  logic [2*WIDTH-1:0]  res_data_q;

  assign wt_hs = bus.wt_valid && (state_q == StLoadW);
  assign px_hs = bus.px_valid && (state_q == StStream);

  conv_win_tracker #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .CU_LAT (CU_LAT)
  ) u_win_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (px_hs),
    .clear   (clear),
    .last_px (last_px),
    .tag_out (tag_out)
  );

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    drain_d = drain_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoadW;
          widx_d  = '0;
          clear   = 1'b1;
        end
      end
      StLoadW: begin
        if (wt_hs) begin
          if (widx_q == 4'(NUM_TAPS - 1)) state_d = StStream;
          else                            widx_d  = widx_q + 4'd1;
        end
      end
      StStream: begin
        drain_d = '0;
        if (last_px) state_d = StDrain;
      end
      StDrain: begin
        // Hold off DONE until the last tag has left the pipeline.
        if (drain_q == DrainW'(CU_LAT)) state_d = StDone;
        else                            drain_d = drain_q + DrainW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      widx_q      <= '0;
      drain_q     <= '0;
      we_q        <= 1'b0;
      weight_q    <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      drain_q     <= drain_d;
      we_q        <= wt_hs;
      en_q        <= px_hs;
      res_valid_q <= tag_out;
      if (wt_hs) begin
        weight_q <= bus.wt_data;
        idx_q    <= widx_q;
      end
      if (px_hs)   data_q     <= bus.px_data;
      if (tag_out) res_data_q <= bus.pe_result;
    end
  end

  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.wt_ready      = (state_q == StLoadW);
  assign bus.px_ready      = (state_q == StStream);
  assign bus.pe_rst_n      = (state_q == StStream) || (state_q == StDrain);
  assign bus.pe_weight     = weight_q;
  assign bus.pe_weight_idx = idx_q;
  assign bus.pe_weight_we  = we_q;
  assign bus.pe_data       = data_q;
  assign bus.pe_data_en    = en_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;

endmodule
